// File: rtl/pulse_stretch_gen.sv
// pulse_stretch_gen: turns one-cycle request strobes into clean level pulses
// of programmable width, each followed by a forced low gap. Requests that
// arrive while a pulse or gap is in progress are counted and replayed
// back-to-back; requests beyond the counter's capacity are dropped and
// flagged in a sticky overflow bit.
//
// Signalling: trig has no back-pressure. Every cycle it is high at a posedge
// is one request, and the block never stalls the sender. done is a one-cycle
// strobe, high in the cycle right after q falls at the end of a pulse.
module pulse_stretch_gen #(
    parameter int LEN_W   = 16,
    parameter int DEF_LEN = 1000,
    parameter int GAP_CYC = 2,
    parameter int PEND_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [LEN_W-1:0]  len,
    input  logic              clr_ovf,
    output logic              q,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);

    // Gap counter is sized just large enough to hold GAP_CYC.
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [LEN_W-1:0]  DEF_L    = LEN_W'(DEF_LEN);
    localparam logic [LEN_W-1:0]  ONE_L    = LEN_W'(1);
    localparam logic [GAP_W-1:0]  GAP_L    = GAP_W'(GAP_CYC);
    localparam logic [GAP_W-1:0]  ONE_G    = GAP_W'(1);
    localparam logic [PEND_W-1:0] ONE_P    = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    // Reject parameter sets that cannot produce a legal pulse train.
    generate
        if (GAP_CYC < 1) begin : g_bad_gap
            $error("pulse_stretch_gen: GAP_CYC must be >= 1");
        end
        if (DEF_LEN < 1 || DEF_LEN > (2 ** LEN_W) - 1) begin : g_bad_def
            $error("pulse_stretch_gen: DEF_LEN must be in 1..2^LEN_W-1");
        end
        if (PEND_W < 1) begin : g_bad_pend
            $error("pulse_stretch_gen: PEND_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  wcnt;
    logic [GAP_W-1:0]  gcnt;

    logic [LEN_W-1:0]  start_len;
    logic              gap_end;
    logic              queue_ok;
    logic              accept;
    logic              drop;

    // Derive pulse length, gap expiry and the queue accept/drop decision.
    // The gap-expiry edge is excluded from normal queueing: there a request
    // either starts the next pulse itself or cancels out a dequeue.
    always_comb begin
        start_len = (len == '0) ? DEF_L : len;
        gap_end   = (state == GAP) && (gcnt <= ONE_G);
        queue_ok  = (state == HIGH) || ((state == GAP) && !gap_end);
        accept    = trig && queue_ok && (pend_cnt != PEND_MAX);
        drop      = trig && queue_ok && (pend_cnt == PEND_MAX);
    end

    assign busy = (state != IDLE);

    // Main sequencer: pulse width, low gap, request counting and overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            q        <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            pend_cnt <= '0;
            wcnt     <= '0;
            gcnt     <= '0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                pend_cnt <= pend_cnt + ONE_P;
            end

            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= HIGH;
                        q     <= 1'b1;
                        wcnt  <= start_len;
                    end
                end
                HIGH: begin
                    // Counter holds L at the start edge, so value 1 marks
                    // the edge that ends the pulse; it never wraps below 0.
                    if (wcnt <= ONE_L) begin
                        state <= GAP;
                        q     <= 1'b0;
                        done  <= 1'b1;
                        wcnt  <= '0;
                        gcnt  <= GAP_L;
                    end else begin
                        wcnt <= wcnt - ONE_L;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        gcnt <= '0;
                        if (pend_cnt != '0 || trig) begin
                            state <= HIGH;
                            q     <= 1'b1;
                            wcnt  <= start_len;
                            // A fresh request at this edge replaces the
                            // dequeued one, leaving the count unchanged.
                            if (pend_cnt != '0 && !trig) begin
                                pend_cnt <= pend_cnt - ONE_P;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gcnt <= gcnt - ONE_G;
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= 1'b0;
                end
            endcase

            // A drop at the same edge as a clear leaves the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
